cm_shr_arb: RTL and testbench
=============================

# cm_shr_arb

Round-robin arbiter that shares one fixed-latency `cm_shr` delay line between `REQ_CNT` requesters. Each requester presents data with a valid/ready handshake. The arbiter grants at most one transfer per cycle and tags the winner's data with its requester ID. The tagged entry then travels through an internal `LEN`-stage `cm_shr`. Per-requester credit counters bound the number of outstanding entries, so a single requester cannot monopolise the pipeline. The block sits between requesters and their fixed-latency return path in the `cm_` common library.

## Interface
Parameters:
- `REQ_CNT`, default 4: number of requesters, ≥1. `IDW = max(1, $clog2(REQ_CNT))`.
- `LEN`, default 3: internal `cm_shr` stages, ≥0.
- `DTYPE`, default `logic [7:0]`: payload type.
- `MAX_OUT`, default 2: maximum outstanding entries per requester, ≥1. Counter width is `$clog2(MAX_OUT+1)`.

Ports:
- `i_clk` in, 1: clock. Single clock domain.
- `i_rst` in, 1: reset. Synchronous and active-high.
- `i_valid` in, `[REQ_CNT]`: requester k offers data.
- `i_data` in, `[REQ_CNT]` × `DTYPE`: requester payloads.
- `o_ready` out, `[REQ_CNT]`: grant, one-hot or zero. This is a combinational function of `i_valid`, the pointer, the credits and the return stage.
- `o_valid` out, 1: result valid.
- `o_id` out, `IDW`: requester ID of the result.
- `o_data` out, `DTYPE`: result payload.

## Operation
- **Eligibility.** Requester k is eligible iff `i_valid[k]` is high and either:
  - `cnt[k] < MAX_OUT`, or
  - `cnt[k] == MAX_OUT` and `o_valid && o_id == k` in the same cycle (credit bypass).
- **Arbitration.**
  - Scan k = ptr, ptr+1, … modulo `REQ_CNT`. The first eligible requester wins, and only its `o_ready` bit is high.
  - A transfer occurs when `i_valid[k] & o_ready[k]`.
  - On a transfer to requester g: ptr ← (g+1) mod `REQ_CNT`.
  - With no transfer, ptr is unchanged.
- **Pipeline.**
  1. The accepted `{valid=1, id=g, data=i_data[g]}` is registered into an input stage.
  2. That stage feeds `cm_shr` with `LEN=LEN`, `RST_MODE=SHR_RST_ALL`, and `DTYPE` = packed struct `{valid, id, data}`.
  3. The `cm_shr` output drives `o_valid`, `o_id` and `o_data` directly.
  4. A cycle with no transfer inserts a bubble (valid=0).
- **Credits.**
  - `cnt[g]` increments on each transfer.
  - `cnt[k]` decrements when `o_valid && o_id == k`.
  - Increment and decrement in the same cycle leave `cnt[k]` unchanged.
  - `cnt` never exceeds `MAX_OUT` and never underflows. Either condition is a design error; the bench asserts on both.
- **No output backpressure.** The consumer always accepts `o_*`.
- **Reset** (`i_rst` high at a clock edge):
  - ptr ← 0, all `cnt` ← 0.
  - Every input and `cm_shr` stage clears to '0, so `o_valid=0`, `o_id=0`, `o_data='0` from the next cycle.
  - In-flight entries are discarded and never appear on the output.
- **During reset.** While `i_rst` is high, `o_ready` is forced to all-zero, so no transfer is accepted.

## Timing
- Latency: data accepted in cycle C appears with `o_valid=1` in cycle C+1+`LEN`. With `LEN=0`, this is the next cycle.
- Throughput: one transfer per cycle total.
- Per-requester throughput:
  - A lone requester sustains 1 per cycle iff `MAX_OUT ≥ LEN+1`.
  - Otherwise it is limited to `MAX_OUT` transfers per `LEN+1` cycles. The bypass removes the extra bubble at the credit limit.
- Combinational path: `i_valid` → `o_ready`. Requesters must not make `i_valid` depend on `o_ready`.
- Simultaneous events:
  - A requester at the credit limit whose result returns in the same cycle it requests is granted.
  - A reset edge coinciding with a return or transfer gives reset priority: the counters end at 0.
- Outputs are registered except `o_ready`.

## Test plan
1. **Reset values.** `REQ_CNT=4`, `LEN=3`. Hold `i_rst` for 2 cycles with all `i_valid=1` → `o_ready=0000` during reset. After reset, `o_valid=0`, `o_id=0`, `o_data=0`.
2. **Round-robin and latency.** `MAX_OUT=4`. All four requesters valid continuously with data 8'h10+k → grants in order 0,1,2,3,0,… one per cycle. Output for the grant in cycle C appears at C+4 with the matching `o_id` and data.
3. **Pointer skip.** Only requesters 1 and 3 valid, ptr=0 → grant 1, then 3, then 1. No cycle is wasted on idle requesters.
4. **Credit limit with bypass.** `LEN=3`, `MAX_OUT=2`, only requester 2 valid → accepts in cycles 0,1, stalls in cycles 2,3, accepts in cycle 4 as the first result returns. The resulting pattern is 2 accepts per 4 cycles, and `cnt[2]` never exceeds 2.
5. **`LEN=0` corner.** `LEN=0`, `REQ_CNT=1`, `MAX_OUT=1`, data 1..15 presented back-to-back → accepted every cycle thanks to the bypass. `o_data` = 1..15 each one cycle after acceptance.
6. **Reset mid-flight.** Pulse `i_rst` for 1 cycle with 3 entries in flight → those entries never produce `o_valid`. Counters return to 0, and the next grant goes to requester 0.

Source files
------------

// File: rtl/cm_shr_arb.sv
// cm_shr_arb -- round-robin arbiter in front of a shared fixed-latency delay line.
//
// REQ_CNT requesters offer payloads with valid/ready. At most one is granted per
// cycle, scanning from a rotating pointer. The winner's payload is tagged with its
// ID and sent through an input stage plus LEN shift stages. Per-requester credit
// counters bound how many entries each requester may have in flight.
//
// Ports
//   i_clk    clock
//   i_rst    synchronous active-high reset; also forces o_ready to zero
//   i_valid  [REQ_CNT]          requester k offers data
//   i_data   [REQ_CNT] x DTYPE  requester payloads
//   o_ready  [REQ_CNT]          grant, one-hot or zero (combinational)
//   o_valid                     result valid, LEN+1 cycles after acceptance
//   o_id     [IDW]              requester ID of the result
//   o_data   DTYPE              result payload

// Credit counter for one requester. A returning result frees its credit in
// the same cycle, so a requester sitting at the limit may still be granted.
module cm_shr_arb_cred #(
    parameter int MAX_OUT = 2,
    parameter int CW      = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_valid,
    input  logic i_ret,
    input  logic i_inc,
    output logic o_elig
);
    localparam logic [CW-1:0] MAXC = CW'(MAX_OUT);

    logic [CW-1:0] r_cnt;

    assign o_elig = i_valid && ((r_cnt < MAXC) || ((r_cnt == MAXC) && i_ret));

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_inc && !i_ret)
            r_cnt <= r_cnt + CW'(1);
        else if (!i_inc && i_ret)
            r_cnt <= r_cnt - CW'(1);
    end
endmodule

module cm_shr_arb #(
    parameter int  REQ_CNT = 4,
    parameter int  LEN     = 3,
    parameter type DTYPE   = logic [7:0],
    parameter int  MAX_OUT = 2,
    localparam int IDW     = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [REQ_CNT-1:0]       i_valid,
    input  DTYPE [REQ_CNT-1:0]       i_data,
    output logic [REQ_CNT-1:0]       o_ready,
    output logic                     o_valid,
    output logic [IDW-1:0]           o_id,
    output DTYPE                     o_data
);
    localparam int CW = $clog2(MAX_OUT + 1);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        DTYPE           data;
    } ent_t;

    logic [IDW-1:0]     r_ptr;
    ent_t               r_pipe [LEN+1];   // [0] is the input stage, [LEN] drives the outputs

    logic [REQ_CNT-1:0] w_ret;
    logic [REQ_CNT-1:0] w_elig;
    logic [REQ_CNT-1:0] w_gnt;
    logic               w_hit;
    logic [IDW-1:0]     w_gid;
    DTYPE               w_gdata;
    int                 w_idx;
    ent_t               w_in;

    // Per-requester return detect and credit tracking
    for (genvar k = 0; k < REQ_CNT; k++) begin : g_req
        assign w_ret[k] = o_valid && (o_id == IDW'(k));

        cm_shr_arb_cred #(
            .MAX_OUT (MAX_OUT),
            .CW      (CW)
        ) u_cred (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_valid (i_valid[k]),
            .i_ret   (w_ret[k]),
            .i_inc   (w_gnt[k]),
            .o_elig  (w_elig[k])
        );
    end

    // First eligible requester at or after the pointer wins. Eligibility
    // already includes i_valid, so any grant is a transfer.
    always_comb begin
        w_gnt   = '0;
        w_hit   = 1'b0;
        w_gid   = '0;
        w_gdata = '0;
        w_idx   = 0;
        if (!i_rst) begin
            for (int i = 0; i < REQ_CNT; i++) begin
                w_idx = (int'(r_ptr) + i) % REQ_CNT;
                if (!w_hit && w_elig[w_idx]) begin
                    w_hit        = 1'b1;
                    w_gnt[w_idx] = 1'b1;
                    w_gid        = IDW'(w_idx);
                    w_gdata      = i_data[w_idx];
                end
            end
        end
    end

    assign o_ready = w_gnt;

    always_comb begin
        w_in       = '0;
        w_in.valid = w_hit;
        w_in.id    = w_gid;
        w_in.data  = w_gdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_ptr <= '0;
        else if (w_hit)
            r_ptr <= (w_gid == IDW'(REQ_CNT - 1)) ? '0 : w_gid + IDW'(1);
    end

    // Bubbles are loaded as all-zero so idle outputs read 0 rather than stale data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s <= LEN; s++)
                r_pipe[s] <= '0;
        end else begin
            r_pipe[0] <= w_in;
            for (int s = 1; s <= LEN; s++)
                r_pipe[s] <= r_pipe[s-1];
        end
    end

    assign o_valid = r_pipe[LEN].valid;
    assign o_id    = r_pipe[LEN].id;
    assign o_data  = r_pipe[LEN].data;
endmodule

// File: tb/tb_cm_shr_arb.sv
// Bench for cm_shr_arb: three instances (4 req/LEN 3/MAX 2, 4 req/LEN 3/MAX 4,
// 1 req/LEN 0/MAX 1) driven from one stimulus stream and compared each cycle
// against a per-instance model that tracks ptr, credit counts and the
// expected output per future cycle slot.
module tb_cm_shr_arb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [3:0]      vld;
    logic [3:0][7:0] dat;

    logic [3:0] rdy_a, rdy_b;
    logic [0:0] rdy_c;
    logic       ov_a, ov_b, ov_c;
    logic [1:0] oid_a, oid_b;
    logic [0:0] oid_c;
    logic [7:0] od_a, od_b, od_c;

    cm_shr_arb #(.REQ_CNT(4), .LEN(3), .MAX_OUT(2)) u_a (
        .i_clk(clk), .i_rst(rst), .i_valid(vld), .i_data(dat),
        .o_ready(rdy_a), .o_valid(ov_a), .o_id(oid_a), .o_data(od_a));
    cm_shr_arb #(.REQ_CNT(4), .LEN(3), .MAX_OUT(4)) u_b (
        .i_clk(clk), .i_rst(rst), .i_valid(vld), .i_data(dat),
        .o_ready(rdy_b), .o_valid(ov_b), .o_id(oid_b), .o_data(od_b));
    cm_shr_arb #(.REQ_CNT(1), .LEN(0), .MAX_OUT(1)) u_c (
        .i_clk(clk), .i_rst(rst), .i_valid(vld[0:0]), .i_data(dat[0:0]),
        .o_ready(rdy_c), .o_valid(ov_c), .o_id(oid_c), .o_data(od_c));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // model state, one row per instance
    int         m_n   [3] = '{4, 4, 1};
    int         m_len [3] = '{3, 3, 0};
    int         m_max [3] = '{2, 4, 1};
    int         m_ptr [3];
    int         m_cnt [3][4];
    logic       m_ev  [3][8];
    int         m_eid [3][8];
    logic [7:0] m_ed  [3][8];
    bit         armed = 0;
    int         cyc = 0;

    logic       o_v [3];
    int         o_i [3];
    logic [7:0] o_d [3];
    logic [3:0] o_r [3];

    task automatic model(input int d, input logic r, input logic [3:0] v, input logic [3:0][7:0] dd);
        int slot, g;
        logic xv;
        int xid;
        logic [3:0] xr;
        string nm;
        nm = (d == 0) ? "A" : (d == 1) ? "B" : "C";
        slot = cyc % 8;
        xv = m_ev[d][slot];
        xid = m_eid[d][slot];
        if (armed) begin
            chk({nm, ".o_valid"}, o_v[d], xv);
            chk({nm, ".o_id"}, o_i[d], xv ? xid : 0);
            chk({nm, ".o_data"}, o_d[d], xv ? m_ed[d][slot] : 8'h00);
        end
        m_ev[d][slot] = 1'b0;
        xr = '0;
        g = -1;
        if (!r) begin
            for (int i = 0; i < m_n[d]; i++) begin
                int k;
                k = (m_ptr[d] + i) % m_n[d];
                if (g < 0 && v[k] &&
                    (m_cnt[d][k] < m_max[d] || (m_cnt[d][k] == m_max[d] && xv && xid == k)))
                    g = k;
            end
            if (g >= 0) xr[g] = 1'b1;
        end
        chk({nm, ".o_ready"}, o_r[d], xr);
        if (r) begin
            m_ptr[d] = 0;
            for (int k = 0; k < 4; k++) m_cnt[d][k] = 0;
            for (int s = 0; s < 8; s++) m_ev[d][s] = 1'b0;
        end else begin
            if (g >= 0) begin
                int ns;
                ns = (cyc + 1 + m_len[d]) % 8;
                m_ev[d][ns] = 1'b1;
                m_eid[d][ns] = g;
                m_ed[d][ns] = dd[g];
                m_cnt[d][g]++;
                m_ptr[d] = (g + 1) % m_n[d];
            end
            if (xv) m_cnt[d][xid]--;
            for (int k = 0; k < m_n[d]; k++)
                if (m_cnt[d][k] < 0 || m_cnt[d][k] > m_max[d])
                    chk({nm, ".cnt_range"}, m_cnt[d][k], m_max[d]);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] v, input logic [3:0][7:0] dd);
        @(negedge clk);
        o_v[0] = ov_a; o_i[0] = oid_a; o_d[0] = od_a;
        o_v[1] = ov_b; o_i[1] = oid_b; o_d[1] = od_b;
        o_v[2] = ov_c; o_i[2] = oid_c; o_d[2] = od_c;
        rst = r; vld = v; dat = dd;
        #1;
        o_r[0] = rdy_a; o_r[1] = rdy_b; o_r[2] = {3'b000, rdy_c};
        for (int d = 0; d < 3; d++) model(d, r, v, dd);
        if (r) armed = 1;
        cyc++;
    endtask

    logic [3:0][7:0] pat;
    logic [3:0][7:0] rnd;

    initial begin
        rst = 1'b1; vld = '0; dat = '0;
        for (int k = 0; k < 4; k++) pat[k] = 8'h10 + 8'(k);
        for (int s = 0; s < 8; s++)
            for (int d = 0; d < 3; d++) m_ev[d][s] = 1'b0;

        // reset with everyone requesting: no grants
        repeat (2) step(1'b1, 4'b1111, pat);
        // full load: round robin, one grant per cycle
        repeat (20) step(1'b0, 4'b1111, pat);
        // pointer skip over idle requesters
        step(1'b1, 4'b0000, pat);
        repeat (10) step(1'b0, 4'b1010, pat);
        // lone requester against its credit limit
        step(1'b1, 4'b0000, pat);
        repeat (12) step(1'b0, 4'b0100, pat);
        // back-to-back data 1..15 on requester 0 (zero-length instance relies on bypass)
        step(1'b1, 4'b0000, pat);
        for (int i = 1; i <= 15; i++) begin
            rnd = pat;
            rnd[0] = 8'(i);
            step(1'b0, 4'b0001, rnd);
        end
        repeat (4) step(1'b0, 4'b0000, pat);
        // reset with entries in flight
        repeat (3) step(1'b0, 4'b1111, pat);
        step(1'b1, 4'b1111, pat);
        repeat (10) step(1'b0, 4'b1111, pat);
        // random traffic with occasional reset
        repeat (400) begin
            for (int k = 0; k < 4; k++) rnd[k] = 8'($urandom);
            step(($urandom_range(0, 49) == 0), 4'($urandom), rnd);
        end
        repeat (8) step(1'b0, 4'b0000, pat);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
